// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter sharing one single-user resource between N requesters.
// Registered one-hot grant held until done, withdrawal or hold timeout, then one dead cycle.
`timescale 1ns/1ps

module rr_resource_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    parameter int IW       = $clog2(N),
    parameter int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id,
    output logic          busy,
    output logic          timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  grant_n;
    logic [IW-1:0] grant_id_n;
    logic          busy_n;
    logic          timeout_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] ptr, ptr_n;

    logic          win_valid;
    logic [IW-1:0] win_id;

    // Rotating priority scan: the lowest offset from ptr with an active request wins.
    always_comb begin
        logic [IW-1:0] cand;
        win_valid = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int off = N - 1; off >= 0; off--) begin
            cand = IW'((int'(ptr) + off) % N);
            if (req[cand]) begin
                win_valid = 1'b1;
                win_id    = cand;
            end
        end
    end

    logic          hold_expired;
    logic          owner_present;
    logic          release_now;

    assign hold_expired  = (cnt == CW'(MAX_HOLD - 1));
    assign owner_present = req[grant_id];
    assign release_now   = done || !owner_present || hold_expired;

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_n    = state;
        grant_n    = grant;
        grant_id_n = grant_id;
        busy_n     = busy;
        timeout_n  = 1'b0;
        cnt_n      = cnt;
        ptr_n      = ptr;

        unique case (state)
            ST_IDLE, ST_RELEASE: begin
                cnt_n = '0;
                if (win_valid) begin
                    grant_n           = '0;
                    grant_n[win_id]   = 1'b1;
                    grant_id_n        = win_id;
                    busy_n            = 1'b1;
                    state_n           = ST_BUSY;
                end else begin
                    grant_n    = '0;
                    grant_id_n = '0;
                    busy_n     = 1'b0;
                    state_n    = ST_IDLE;
                end
            end

            ST_BUSY: begin
                if (cnt != CW'(MAX_HOLD))
                    cnt_n = cnt + CW'(1);
                if (release_now) begin
                    // A timeout is only reported when neither done nor withdrawal claimed the release.
                    timeout_n  = !done && owner_present && hold_expired;
                    grant_n    = '0;
                    grant_id_n = '0;
                    busy_n     = 1'b0;
                    ptr_n      = IW'((int'(grant_id) + 1) % N);
                    state_n    = ST_RELEASE;
                end
            end

            default: begin
                grant_n    = '0;
                grant_id_n = '0;
                busy_n     = 1'b0;
                cnt_n      = '0;
                state_n    = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the reset branch clears all of them, including ptr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            cnt      <= '0;
            ptr      <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            grant_id <= grant_id_n;
            busy     <= busy_n;
            timeout  <= timeout_n;
            cnt      <= cnt_n;
            ptr      <= ptr_n;
        end
    end

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Directed bench for rr_resource_arbiter: each step drives inputs, queues the
// hand-derived expected outputs, and checks them one edge later.
`timescale 1ns/1ps

module tb_rr_resource_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;
    localparam int IW       = $clog2(N);

    logic          clk;
    logic          reset;
    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_id;
    logic          busy;
    logic          timeout;

    typedef struct {
        logic [N-1:0]  grant;
        logic [IW-1:0] id;
        logic          busy;
        logic          timeout;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    rr_resource_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input logic [N-1:0] g, input logic [IW-1:0] id,
                              input logic b, input logic t);
        exp_t e;
        e.grant = g; e.id = id; e.busy = b; e.timeout = t;
        sb.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ".queue_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, ".grant"},    32'(grant),    32'(e.grant));
        check({tag, ".grant_id"}, 32'(grant_id), 32'(e.id));
        check({tag, ".busy"},     32'(busy),     32'(e.busy));
        check({tag, ".timeout"},  32'(timeout),  32'(e.timeout));
        check({tag, ".onehot0"},  32'($onehot0(grant)), 32'd1);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked 1 unit after the next one.
    task automatic step(input string tag, input logic [N-1:0] r, input logic d,
                        input logic [N-1:0] g, input logic [IW-1:0] id,
                        input logic b, input logic t);
        req  = r;
        done = d;
        expect_out(g, id, b, t);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic do_reset(input string tag);
        req   = '0;
        done  = 1'b0;
        reset = 1'b1;
        #2;
        expect_out('0, '0, 1'b0, 1'b0);
        compare_out(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        done  = 1'b0;
        @(posedge clk);
        #1;

        // 1: single requester, done on the third busy cycle, then idle
        do_reset("t1_reset");
        step("t1_grant",  4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        step("t1_hold1",  4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        step("t1_hold2",  4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        step("t1_done",   4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step("t1_dead",   4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        step("t1_idle_done_ignored", 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step("t1_idle",   4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

        // 2: all requesting, done on the 2nd cycle of each grant -> full rotation
        do_reset("t2_reset");
        for (int k = 0; k < 5; k++) begin
            logic [IW-1:0] id;
            logic [N-1:0]  oh;
            id = IW'(k % N);
            oh = '0;
            oh[id] = 1'b1;
            step($sformatf("t2_grant%0d", k), 4'b1111, 1'b0, oh, id, 1'b1, 1'b0);
            step($sformatf("t2_hold%0d", k),  4'b1111, 1'b0, oh, id, 1'b1, 1'b0);
            step($sformatf("t2_dead%0d", k),  4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        end

        // 3: hold timeout after exactly MAX_HOLD cycles, then next owner after dead cycle
        do_reset("t3_reset");
        step("t3_grant", 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int c = 2; c <= MAX_HOLD; c++)
            step($sformatf("t3_hold%0d", c), 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step("t3_timeout", 4'b0011, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
        step("t3_next",    4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        step("t3_release", 4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

        // 4: requester 2 withdraws; rotation then favours 3 over 0
        do_reset("t4_reset");
        step("t4_grant",    4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step("t4_hold",     4'b1100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step("t4_withdraw", 4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        step("t4_rotate3",  4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        step("t4_done",     4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step("t4_rotate0",  4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);

        // 5: done coincides with the hold limit -> normal release, no timeout
        do_reset("t5_reset");
        step("t5_grant", 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int c = 2; c <= MAX_HOLD; c++)
            step($sformatf("t5_hold%0d", c), 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step("t5_done_at_limit", 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step("t5_idle",          4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

        // 6: asynchronous reset mid-busy, then restart from ptr 0
        do_reset("t6_reset");
        step("t6_grant", 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        step("t6_hold",  4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        expect_out('0, '0, 1'b0, 1'b0);
        compare_out("t6_async_reset");
        #1;
        req   = 4'b1000;
        reset = 1'b0;
        @(posedge clk);
        #1;
        expect_out(4'b1000, 2'd3, 1'b1, 1'b0);
        compare_out("t6_after_reset");

        // ptr is 0 after reset, so requester 1 must beat requester 2 once 3 releases
        step("t6_done",   4'b0110, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        step("t6_ptr0",   4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
